// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: IF1 packet, queue entry, NOP and exception-code width.
package fetch_pkg;

  localparam int          EXCP_W   = 7;
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic [1:0]        pc_taken;
    logic [31:0]       inst0;
    logic [31:0]       inst1;
    logic [31:0]       badv;
    logic [EXCP_W-1:0] exception;
    logic [1:0]        excp_flag;
  } fetch_pkt_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              excp;
    logic [EXCP_W-1:0] exception;
    logic [31:0]       badv;
  } fq_entry_t;

  function automatic fq_entry_t nop_entry();
    fq_entry_t e;
    e      = '0;
    e.inst = INST_NOP;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x fq_entry_t registers, two write ports at wr_addr/wr_addr+1,
// two asynchronous read ports at rd_addr/rd_addr+1; the +1 wraps by index masking.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [LOG_DEPTH-1:0] wr_addr,
  input  fq_entry_t            wd0,
  input  fq_entry_t            wd1,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output fq_entry_t            rd0,
  output fq_entry_t            rd1
);

  localparam logic [LOG_DEPTH-1:0] MASK = LOG_DEPTH'(DEPTH - 1);

  fq_entry_t            mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_addr1;
  logic [LOG_DEPTH-1:0] rd_addr1;

  assign wr_addr1 = (wr_addr + LOG_DEPTH'(1)) & MASK;
  assign rd_addr1 = (rd_addr + LOG_DEPTH'(1)) & MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= nop_entry();
    end else begin
      if (we0) mem[wr_addr & MASK] <= wd0;
      if (we1) mem[wr_addr1]       <= wd1;
    end
  end

  assign rd0 = mem[rd_addr & MASK];
  assign rd1 = mem[rd_addr1];

endmodule

// File: rtl/fetch_queue.sv
// IF1-to-decode instruction queue: splits packets into entries, issues up to two per cycle in order.
// Write-to-output latency 1 cycle (0 with FETCH_QUEUE_BYPASS_EN); accepts a packet only while free >= 2.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_pc_next,
  input  logic [1:0]        in_pc_taken,
  input  logic [31:0]       in_inst0,
  input  logic [31:0]       in_inst1,
  input  logic [31:0]       in_badv,
  input  logic [6:0]        in_exception,
  input  logic [1:0]        in_excp_flag,
  output logic              fifo_allowin,
  output logic              write_en,
  output logic              pop_en,
  output logic              space_ok,
  output logic              nearly_full,
  output logic [1:0]        out_valid,
  output logic [31:0]       out_pc0,
  output logic [31:0]       out_pc1,
  output logic [31:0]       out_inst0,
  output logic [31:0]       out_inst1,
  output logic [1:0]        out_pred_taken,
  output logic [31:0]       out_pred_target0,
  output logic [31:0]       out_pred_target1,
  output logic [1:0]        out_excp,
  output logic [6:0]        out_exception,
  output logic [31:0]       out_badv,
  input  logic [1:0]        out_accept
);

  localparam int CW = LOG_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]        count, free;

  fetch_pkt_t pkt;
  fq_entry_t  pk0, pk1, rd0, rd1, lane0, lane1, wd0;
  logic [1:0] pk_n, pops, wr_n, rd_pops;
  logic       byp, raw_v0, raw_v1, acc0, acc1;

  assign pkt = '{pc: in_pc, pc_next: in_pc_next, pc_taken: in_pc_taken, inst0: in_inst0,
                 inst1: in_inst1, badv: in_badv, exception: in_exception, excp_flag: in_excp_flag};

  // An odd-word PC fetches only slot 1; a taken or faulting slot 0 ends the packet.
  always_comb begin
    pk0 = nop_entry();
    pk1 = nop_entry();
    pk0.pc = pkt.pc;
    if (pkt.pc[2]) begin
      pk0.inst       = pkt.inst1;
      pk0.pred_taken = pkt.pc_taken[1];
      pk0.excp       = pkt.excp_flag[1];
      pk_n           = 2'd1;
    end else begin
      pk0.inst       = pkt.inst0;
      pk0.pred_taken = pkt.pc_taken[0];
      pk0.excp       = pkt.excp_flag[0];
      pk_n           = (pkt.pc_taken[0] || pkt.excp_flag[0]) ? 2'd1 : 2'd2;
    end
    pk0.pred_target = (pk_n == 2'd1) ? pkt.pc_next : pkt.pc + 32'd4;
    pk0.exception   = pk0.excp ? pkt.exception : '0;
    pk0.badv        = pk0.excp ? pkt.badv : '0;

    pk1.pc          = pkt.pc + 32'd4;
    pk1.inst        = pkt.inst1;
    pk1.pred_taken  = pkt.pc_taken[1];
    pk1.pred_target = pkt.pc_next;
    pk1.excp        = pkt.excp_flag[1];
    pk1.exception   = pk1.excp ? pkt.exception : '0;
    pk1.badv        = pk1.excp ? pkt.badv : '0;
  end

  assign free         = DEPTH_C - count;
  assign fifo_allowin = free >= CW'(2);
  assign space_ok     = free >= CW'(4);
  assign nearly_full  = free < CW'(2);
  assign write_en     = in_valid && fifo_allowin && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count == '0) && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign lane0  = byp ? pk0 : rd0;
  assign lane1  = byp ? pk1 : rd1;
  assign raw_v0 = byp ? 1'b1 : (count != '0);
  assign raw_v1 = byp ? (pk_n == 2'd2) : (count >= CW'(2));

  // A taken or faulting head must close its issue group.
  assign out_valid = {raw_v0 && raw_v1 && !lane0.excp && !lane0.pred_taken, raw_v0};

  assign acc0    = out_accept[0] && out_valid[0];
  assign acc1    = out_accept[1] && out_valid[1] && acc0;
  assign pops    = {1'b0, acc0} + {1'b0, acc1};
  assign pop_en  = acc0 && !flush;
  assign rd_pops = byp ? 2'd0 : pops;
  assign wr_n    = write_en ? (pk_n - (byp ? pops : 2'd0)) : 2'd0;
  assign wd0     = (byp && acc0) ? pk1 : pk0;

  fetch_queue_ram #(.DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we0     (wr_n != 2'd0),
    .we1     (wr_n == 2'd2),
    .wr_addr (wr_ptr),
    .wd0     (wd0),
    .wd1     (pk1),
    .rd_addr (rd_ptr),
    .rd0     (rd0),
    .rd1     (rd1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + LOG_DEPTH'(wr_n);
      rd_ptr <= rd_ptr + LOG_DEPTH'(rd_pops);
      count  <= count + CW'(wr_n) - CW'(rd_pops);
    end
  end

  assign out_pc0          = lane0.pc;
  assign out_pc1          = lane1.pc;
  assign out_inst0        = lane0.inst;
  assign out_inst1        = lane1.inst;
  assign out_pred_taken   = {lane1.pred_taken, lane0.pred_taken};
  assign out_pred_target0 = lane0.pred_target;
  assign out_pred_target1 = lane1.pred_target;
  assign out_excp         = {lane1.excp, lane0.excp};
  assign out_exception    = lane0.excp ? lane0.exception : lane1.exception;
  assign out_badv         = lane0.excp ? lane0.badv : lane1.badv;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH 8): reset, split, full, wrap, hold-back, flush.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [31:0] in_pc, in_pc_next, in_inst0, in_inst1, in_badv;
  logic [1:0]  in_pc_taken, in_excp_flag;
  logic [6:0]  in_exception;
  logic        fifo_allowin, write_en, pop_en, space_ok, nearly_full;
  logic [1:0]  out_valid, out_pred_taken, out_excp, out_accept;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_pred_target0, out_pred_target1, out_badv;
  logic [6:0]  out_exception;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0340_0000;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(8), .LOG_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_pc_next(in_pc_next), .in_pc_taken(in_pc_taken), .in_inst0(in_inst0),
    .in_inst1(in_inst1), .in_badv(in_badv), .in_exception(in_exception),
    .in_excp_flag(in_excp_flag), .fifo_allowin(fifo_allowin), .write_en(write_en),
    .pop_en(pop_en), .space_ok(space_ok), .nearly_full(nearly_full), .out_valid(out_valid),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pred_taken(out_pred_taken), .out_pred_target0(out_pred_target0),
    .out_pred_target1(out_pred_target1), .out_excp(out_excp), .out_exception(out_exception),
    .out_badv(out_badv), .out_accept(out_accept)
  );

  // Decode-side legality: thermometer-coded and never accepting an invalid lane.
  always @(negedge clk) begin
    if (!rst && ((out_accept[1] && !out_accept[0]) || ((out_accept & ~out_valid) != 2'b00))) begin
      n_bad++;
      $display("FAIL accept_rule: out_accept=%b out_valid=%b", out_accept, out_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    flush      = 1'b0;
    out_accept = 2'b00;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic [31:0] pc_next,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] taken, input logic [1:0] excp,
                         input logic [6:0] code, input logic [31:0] badv);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_pc_next   = pc_next;
    in_inst0     = i0;
    in_inst1     = i1;
    in_pc_taken  = taken;
    in_excp_flag = excp;
    in_exception = code;
    in_badv      = badv;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL rst_valid: got %b want 00", out_valid); end
    n_cmp++; if (fifo_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_allowin: got %b want 1", fifo_allowin); end
    n_cmp++; if (space_ok !== 1'b1) begin n_bad++; $display("FAIL rst_space_ok: got %b want 1", space_ok); end
    n_cmp++; if (nearly_full !== 1'b0) begin n_bad++; $display("FAIL rst_nearly_full: got %b want 0", nearly_full); end
    n_cmp++; if ({write_en, pop_en} !== 2'b00) begin n_bad++; $display("FAIL rst_we_pop: got %b want 00", {write_en, pop_en}); end
    n_cmp++; if (out_pc0 !== 32'h0) begin n_bad++; $display("FAIL rst_pc0: got %h want 0", out_pc0); end
    n_cmp++; if (out_inst0 !== NOP || out_inst1 !== NOP) begin n_bad++; $display("FAIL rst_inst: got %h/%h want %h", out_inst0, out_inst1, NOP); end
    n_cmp++; if ({out_excp, out_exception, out_badv} !== '0) begin n_bad++; $display("FAIL rst_excp: got %b %h %h want 0", out_excp, out_exception, out_badv); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_inst();
    set_pkt(32'h1C00_0000, 32'h1C00_0100, 32'h1111_0000, 32'h1111_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    #1;
    n_cmp++; if (write_en !== 1'b1) begin n_bad++; $display("FAIL two_write_en: got %b want 1", write_en); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL two_latency: got %b want 00", out_valid); end
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b11) begin n_bad++; $display("FAIL two_valid: got %b want 11", out_valid); end
    n_cmp++; if (out_pc0 !== 32'h1C00_0000 || out_pc1 !== 32'h1C00_0004) begin n_bad++; $display("FAIL two_pc: got %h/%h want 1c000000/1c000004", out_pc0, out_pc1); end
    n_cmp++; if (out_inst0 !== 32'h1111_0000 || out_inst1 !== 32'h1111_0001) begin n_bad++; $display("FAIL two_inst: got %h/%h want 11110000/11110001", out_inst0, out_inst1); end
    n_cmp++; if (out_pred_target0 !== 32'h1C00_0004 || out_pred_target1 !== 32'h1C00_0100) begin n_bad++; $display("FAIL two_target: got %h/%h want 1c000004/1c000100", out_pred_target0, out_pred_target1); end
    out_accept = 2'b11; #1;
    n_cmp++; if (pop_en !== 1'b1) begin n_bad++; $display("FAIL two_pop_en: got %b want 1", pop_en); end
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL two_drained: got %b want 00", out_valid); end
  endtask

  task automatic test_odd_pc();
    set_pkt(32'h1C00_0004, 32'h1C00_0010, 32'h2222_0000, 32'h2222_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b01) begin n_bad++; $display("FAIL odd_valid: got %b want 01", out_valid); end
    n_cmp++; if (out_inst0 !== 32'h2222_0001) begin n_bad++; $display("FAIL odd_inst0: got %h want 22220001", out_inst0); end
    n_cmp++; if (out_pc0 !== 32'h1C00_0004 || out_pred_target0 !== 32'h1C00_0010) begin n_bad++; $display("FAIL odd_pc_target: got %h/%h want 1c000004/1c000010", out_pc0, out_pred_target0); end
    out_accept = 2'b01;
    tick(); idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_pkt(32'h100 + 32'(8 * i), 32'h108 + 32'(8 * i), 32'h3000 + 32'(2 * i), 32'h3001 + 32'(2 * i), 2'b00, 2'b00, 7'h0, 32'h0);
      tick();
      if (i == 2) begin
        n_cmp++; if ({fifo_allowin, space_ok, nearly_full} !== 3'b100) begin n_bad++; $display("FAIL six_status: got %b want 100", {fifo_allowin, space_ok, nearly_full}); end
      end
    end
    idle(); #1;
    n_cmp++; if ({fifo_allowin, space_ok, nearly_full} !== 3'b001) begin n_bad++; $display("FAIL full_status: got %b want 001", {fifo_allowin, space_ok, nearly_full}); end
    set_pkt(32'h200, 32'h208, 32'hDEAD_0000, 32'hDEAD_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    #1;
    n_cmp++; if (write_en !== 1'b0) begin n_bad++; $display("FAIL full_drop: got %b want 0", write_en); end
    tick(); idle(); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'h100 + 32'(8 * i) || out_pc1 !== 32'h104 + 32'(8 * i))
        begin n_bad++; $display("FAIL full_drain%0d: got %b %h/%h want 11 %h/%h", i, out_valid, out_pc0, out_pc1, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i)); end
      out_accept = 2'b11;
      tick();
    end
    idle(); #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL full_empty: got %b want 00", out_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      set_pkt(32'h300 + 32'(8 * i), 32'h308 + 32'(8 * i), 32'h4000 + 32'(i), 32'h4100 + 32'(i), 2'b00, 2'b00, 7'h0, 32'h0);
      tick();
    end
    set_pkt(32'h31C, 32'h400, 32'h4444_0000, 32'h4444_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick(); idle(); #1;
    n_cmp++; if ({fifo_allowin, nearly_full} !== 2'b01) begin n_bad++; $display("FAIL seven_status: got %b want 01", {fifo_allowin, nearly_full}); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'h300 + 32'(8 * i) || out_pc1 !== 32'h304 + 32'(8 * i))
        begin n_bad++; $display("FAIL wrap_pair%0d: got %b %h/%h want 11 %h/%h", i, out_valid, out_pc0, out_pc1, 32'h300 + 32'(8 * i), 32'h304 + 32'(8 * i)); end
      out_accept = 2'b11;
      tick();
    end
    out_accept = 2'b00; #1;
    n_cmp++; if (out_valid !== 2'b01 || out_pc0 !== 32'h31C || out_inst0 !== 32'h4444_0001)
      begin n_bad++; $display("FAIL wrap_last: got %b %h %h want 01 31c 44440001", out_valid, out_pc0, out_inst0); end
    out_accept = 2'b01;
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL wrap_empty: got %b want 00", out_valid); end
  endtask

  task automatic test_back_to_back();
    set_pkt(32'h400, 32'h408, 32'h5000_0000, 32'h5000_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick();
    set_pkt(32'h408, 32'h410, 32'h5000_0002, 32'h5000_0003, 2'b00, 2'b00, 7'h0, 32'h0);
    out_accept = 2'b11; #1;
    n_cmp++; if ({write_en, pop_en} !== 2'b11) begin n_bad++; $display("FAIL b2b_we_pop: got %b want 11", {write_en, pop_en}); end
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'h408 || out_inst1 !== 32'h5000_0003)
      begin n_bad++; $display("FAIL b2b_head: got %b %h %h want 11 408 50000003", out_valid, out_pc0, out_inst1); end
    out_accept = 2'b11;
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL b2b_empty: got %b want 00", out_valid); end
  endtask

  task automatic test_holdback();
    set_pkt(32'h500, 32'h600, 32'h5550_0000, 32'h5550_0001, 2'b00, 2'b01, 7'h08, 32'hBADD_0500);
    tick();
    set_pkt(32'h600, 32'h700, 32'h6660_0000, 32'h6660_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b01 || out_excp !== 2'b01) begin n_bad++; $display("FAIL excp_valid: got %b excp %b want 01 01", out_valid, out_excp); end
    n_cmp++; if (out_exception !== 7'h08 || out_badv !== 32'hBADD_0500) begin n_bad++; $display("FAIL excp_fields: got %h %h want 08 badd0500", out_exception, out_badv); end
    n_cmp++; if (out_pc0 !== 32'h500 || out_inst0 !== 32'h5550_0000 || out_pred_target0 !== 32'h600)
      begin n_bad++; $display("FAIL excp_entry: got %h %h %h want 500 55500000 600", out_pc0, out_inst0, out_pred_target0); end
    out_accept = 2'b01;
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'h600 || out_excp !== 2'b00)
      begin n_bad++; $display("FAIL excp_next: got %b %h %b want 11 600 00", out_valid, out_pc0, out_excp); end
    out_accept = 2'b11;
    tick();
    set_pkt(32'h700, 32'h900, 32'h7770_0000, 32'h7770_0001, 2'b01, 2'b00, 7'h0, 32'h0);
    out_accept = 2'b00;
    tick();
    set_pkt(32'h900, 32'h908, 32'h9990_0000, 32'h9990_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b01 || out_pred_taken !== 2'b01 || out_pred_target0 !== 32'h900)
      begin n_bad++; $display("FAIL taken_hold: got %b %b %h want 01 01 900", out_valid, out_pred_taken, out_pred_target0); end
    out_accept = 2'b01;
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'h900) begin n_bad++; $display("FAIL taken_next: got %b %h want 11 900", out_valid, out_pc0); end
    out_accept = 2'b11;
    tick(); idle();
  endtask

  task automatic test_flush();
    set_pkt(32'hA00, 32'hA08, 32'hAAAA_0000, 32'hAAAA_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick();
    set_pkt(32'hB00, 32'hB08, 32'hBBBB_0000, 32'hBBBB_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    out_accept = 2'b11;
    flush      = 1'b1;
    #1;
    n_cmp++; if ({write_en, pop_en} !== 2'b00) begin n_bad++; $display("FAIL flush_we_pop: got %b want 00", {write_en, pop_en}); end
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b00 || fifo_allowin !== 1'b1 || space_ok !== 1'b1)
      begin n_bad++; $display("FAIL flush_empty: got %b allow %b space %b want 00 1 1", out_valid, fifo_allowin, space_ok); end
    set_pkt(32'hC00, 32'hC08, 32'hCCCC_0000, 32'hCCCC_0001, 2'b00, 2'b00, 7'h0, 32'h0);
    tick(); idle(); #1;
    n_cmp++; if (out_valid !== 2'b11 || out_pc0 !== 32'hC00 || out_inst0 !== 32'hCCCC_0000)
      begin n_bad++; $display("FAIL flush_reuse: got %b %h %h want 11 c00 cccc0000", out_valid, out_pc0, out_inst0); end
    out_accept = 2'b11;
    tick(); idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_pkt(32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 7'h0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_two_inst();
    test_odd_pc();
    test_full();
    test_wrap();
    test_back_to_back();
    test_holdback();
    test_flush();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
